// File: rtl/tick_bcd_counter.sv
// Start/stop/clear BCD counter that advances on each rising edge of a divided tick level.
// Optional lap capture register is enabled by defining TICK_BCD_COUNTER_LAP_EN.
module tick_bcd_counter #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_in,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
`ifdef TICK_BCD_COUNTER_LAP_EN
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   lap_count,
`endif
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  wrap
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic           tick_prev_q;
    logic           running_q, running_d;
    logic           wrap_q, wrap_d;
    logic           tick_edge;
    logic           do_inc;
    logic [W-1:0]   count_inc;
    logic           inc_carry;

    assign tick_edge = tick_in & ~tick_prev_q;
    assign do_inc    = tick_edge && (state_q == ST_RUN) && !clear && !stop;

    // Ripple BCD increment; the carry out of the top digit means the count was all 9s.
    always_comb begin
        logic carry;
        carry     = 1'b1;
        count_inc = count_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] >= 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
        inc_carry = carry;
    end

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wrap_d  = 1'b0;

        if (clear) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            if (do_inc) begin
                count_d = count_inc;
                wrap_d  = inc_carry;
            end
            if (stop) begin
                if (state_q == ST_RUN) state_d = ST_PAUSE;
            end else if (start) begin
                if (state_q != ST_RUN) state_d = ST_RUN;
            end
        end

        running_d = (state_d == ST_RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            tick_prev_q <= 1'b1;
            running_q   <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            tick_prev_q <= tick_in;
            running_q   <= running_d;
            wrap_q      <= wrap_d;
        end
    end

`ifdef TICK_BCD_COUNTER_LAP_EN
    logic [W-1:0] lap_q, lap_d;

    // Lap captures the count as it stood before this edge's increment.
    always_comb begin
        lap_d = lap_q;
        if (clear) begin
            lap_d = '0;
        end else if (lap && (state_q != ST_IDLE)) begin
            lap_d = count_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_q <= '0;
        end else begin
            lap_q <= lap_d;
        end
    end

    assign lap_count = lap_q;
`endif

    assign count   = count_q;
    assign running = running_q;
    assign wrap    = wrap_q;

endmodule

// File: doc/tick_bcd_counter.md
Name: tick_bcd_counter

Overview:
- Downstream consumer of the clock divider's divided output `CLK`.
- Runs in the `clk` domain. It treats `CLK` as a data level, not a clock, and detects its rising edges.
- Each detected edge advances a DIGITS-digit BCD counter, which has start/stop/clear control.
- Provides the stopwatch/seconds count that display logic reads.

Parameters:
- DIGITS, 4, number of BCD digits (legal 1..8); count width = 4*DIGITS.

Ports:
- clk  input  1  system clock; every flop in the block is clocked on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- tick_in  input  1  divided clock from clock_divider; synchronous to clk.
- start  input  1  single-cycle request to run.
- stop  input  1  single-cycle request to pause.
- clear  input  1  single-cycle request to zero the count and go idle.
- count  output  4*DIGITS  BCD count; digit 0 sits in bits [3:0].
- running  output  1  high while state==RUN.
- wrap  output  1  one-cycle pulse when the count rolls over from all-9s to 0.

Behaviour:
- Reset, asynchronous, active-high:
  - state=IDLE, count=0, running=0, wrap=0.
  - tick_prev=1, so a high tick_in at reset release does not produce a spurious edge.
- Edge detect:
  - tick_prev registers tick_in every cycle.
  - edge = tick_in & ~tick_prev, using values sampled at the same clk edge.
  - Each tick_in rising transition yields exactly one edge.
- States:
  - IDLE: start -> RUN.
  - RUN: stop -> PAUSE.
  - PAUSE: start -> RUN, count retained.
  - Any state: clear -> IDLE with count=0.
- Control priority within one cycle: clear > stop > start.
  - start+stop together: stop wins. In IDLE nothing happens; in PAUSE it stays PAUSE.
  - start in RUN and stop in IDLE/PAUSE are ignored.
- Counting:
  - Count increments at the clk edge where edge=1, state==RUN, and neither clear nor stop is asserted.
  - Latency: count changes 1 clk after tick_in is first high.
  - An edge in the same cycle as start-from-IDLE/PAUSE is not counted, because state was not yet RUN.
- BCD rules:
  - A digit at 9 rolls to 0 and carries into the next digit.
  - Digits never take values A-F.
- Wrap:
  - All-9s + edge -> count=0, and wrap=1 for exactly one cycle.
  - wrap=0 in every other cycle.
- Registered outputs: running = (state==RUN), registered.
- clear mid-run:
  - count=0 on the next clk edge, and any concurrent edge is discarded.
  - wrap stays 0 even if the count was all-9s.
- Reset mid-operation: all state returns to the reset values immediately (asynchronous).

Optional Feature:
- Macro: TICK_BCD_COUNTER_LAP_EN.
- Defined:
  - Adds input `lap` (1 bit) and output `lap_count` (4*DIGITS, reset 0).
  - On a lap pulse in RUN or PAUSE, lap_count latches the pre-increment value of count at that clk edge.
  - clear zeroes lap_count.
  - lap in IDLE is ignored.
- Not defined:
  - Neither port exists; the logic is identical otherwise.

Test Plan:
- Reset release with tick_in=1, DIGITS=4:
  - count stays 0000 and running=0.
  - start issued while tick_in held high, then no toggles: count stays 0000 (no spurious edge).
- Drive tick_in as clock_divider with divisor=4, then pulse start:
  - after 5 tick_in rising edges, count=0005.
  - each increment lands 1 clk after tick_in rises.
- Preload by running to 0009, then 1 edge -> 0010.
- Continue to 9999, then 1 edge:
  - count=0000.
  - wrap high for exactly 1 clk.
- Control sequences:
  - RUN at 0003, pulse stop -> running=0.
  - 3 edges -> count still 0003.
  - start -> 2 edges -> 0005.
  - start+stop in the same cycle from PAUSE -> remains PAUSE.
  - stop on the same cycle as an edge -> that edge is not counted.
- clear at 0042 in RUN on the same cycle as an edge:
  - count=0000, state IDLE, wrap=0.
  - assert rst mid-run -> all outputs 0 without waiting for a clk edge.
  - with LAP_EN: lap at 0007 -> lap_count=0007, and clear -> lap_count=0000.
